// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - valid/ready stream interface between the reader and its consumer

interface fifo_stream_reader_if #(
   parameter int WIDTH = 8
);
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             m_ready;

   // Producer side: drives valid/data, observes ready
   modport master (
      output m_valid,
      output m_data,
      input  m_ready
   );

   // Consumer side: observes valid/data, drives ready
   modport slave (
      input  m_valid,
      input  m_data,
      output m_ready
   );
endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-side bridge with 3-entry skid buffer and beat counter

module fifo_stream_reader #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 fifo_empty,
   input  logic [WIDTH-1:0]     fifo_data,
   output logic                 fifo_rd_en,
   input  logic                 flush,
   fifo_stream_reader_if.master m_if,
   output logic [CNT_W-1:0]     beat_cnt
);

   logic [1:0]       occ_q, occ_d;
   logic             inflight_q, inflight_d;
   logic [1:0]       rd_ptr_q, rd_ptr_d;
   logic [1:0]       wr_ptr_q, wr_ptr_d;
   logic [WIDTH-1:0] buf_q [3];
   logic [WIDTH-1:0] buf_d [3];
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

   logic [2:0]       pending;
   logic             capture;
   logic             pop;
   logic [WIDTH-1:0] head_data;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Words already buffered plus the one in flight must leave room for a new read,
   // so the three slots can never overflow; m_ready is deliberately not used here.
   assign pending    = {1'b0, occ_q} + {2'b00, inflight_q};
   assign fifo_rd_en = reset_n && !fifo_empty && !flush && (pending <= 3'd2);

   // A flush discards the word arriving from last cycle's read
   assign capture = inflight_q && !flush;
   assign pop     = m_if.m_valid && m_if.m_ready;

   assign m_if.m_valid = (occ_q != 2'd0);
   assign m_if.m_data  = m_if.m_valid ? head_data : '0;
   assign beat_cnt     = beat_cnt_q;

   // Select the buffer head without indexing past the third slot
   always_comb begin
      head_data = buf_q[0];
      for (int i = 1; i < 3; i++) begin
         if (rd_ptr_q == 2'(i)) begin
            head_data = buf_q[i];
         end
      end
   end

   // Next-state: capture, pop, occupancy, flush and delivered-beat count
   always_comb begin
      occ_d      = occ_q;
      inflight_d = fifo_rd_en;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      buf_d      = buf_q;
      beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, pop};

      if (flush) begin
         occ_d      = 2'd0;
         inflight_d = 1'b0;
         rd_ptr_d   = 2'd0;
         wr_ptr_d   = 2'd0;
      end else begin
         if (capture) begin
            for (int i = 0; i < 3; i++) begin
               if (wr_ptr_q == 2'(i)) begin
                  buf_d[i] = fifo_data;
               end
            end
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         case ({capture, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
         endcase
      end
   end

   // State registers; reset drops all buffered and in-flight data immediately
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         rd_ptr_q   <= 2'd0;
         wr_ptr_q   <= 2'd0;
         beat_cnt_q <= '0;
         for (int i = 0; i < 3; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         buf_q      <= buf_d;
      end
   end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side bridge between a synchronous FIFO and a downstream valid/ready stream consumer.
- Issues FIFO read strobes and absorbs the FIFO's 1-cycle registered read latency in a 3-entry skid buffer.
- Presents data as a standard valid/ready stream at full throughput, with no combinational path from m_ready to fifo_rd_en.
- Counts delivered beats for debug and status.

Parameters:
WIDTH, 8, data word width in bits
CNT_W, 16, width of the delivered-beat counter

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
fifo_empty  input  1  FIFO true-empty flag (no unread words)
fifo_data  input  WIDTH  FIFO read data, valid the cycle after fifo_rd_en was high
fifo_rd_en  output  1  FIFO read strobe, one word per high cycle
flush  input  1  synchronous flush of buffered and in-flight data
m_valid  output  1  stream data valid
m_data  output  WIDTH  stream data (head of skid buffer)
m_ready  input  1  downstream accept
beat_cnt  output  CNT_W  count of accepted stream beats, wraps modulo 2^CNT_W

Behaviour:
- Clocking and reset: one clock domain.
  - reset_n is asynchronous, active-low; all state clears immediately on assertion; release is synchronous to clk.
  - Reset values: occ=0, inflight=0, buffer pointers=0, m_valid=0, m_data=0, beat_cnt=0, fifo_rd_en=0.
  - fifo_rd_en is held 0 while reset_n is low, regardless of fifo_empty.
- State:
  - 3-entry circular buffer with rd_ptr/wr_ptr, each 2 bits, wrapping 2->0.
  - occ, 2 bits, range 0..3.
  - inflight, 1 bit: registered copy of the previous cycle's fifo_rd_en.
- Read issue (combinational from registered state only):
  - fifo_rd_en = !fifo_empty && !flush && (occ + inflight) <= 2.
  - m_ready never feeds fifo_rd_en.
- Capture: when inflight=1 and flush=0, fifo_data is written to buffer[wr_ptr] at the clock edge and wr_ptr advances.
- Output:
  - m_valid = (occ != 0).
  - m_data = buffer[rd_ptr], 0 when empty.
  - m_data is stable while m_valid=1 and m_ready=0.
  - Pop on m_valid && m_ready; rd_ptr advances.
- Occupancy: occ_next = occ + capture - pop. Simultaneous capture and pop leaves occ unchanged, including at occ=3.
- Overflow never occurs: the issue rule guarantees occ + inflight + new read <= 3 at every edge.
- Throughput: with fifo_empty=0 and m_ready=1 held, steady state is occ=1, inflight=1, one beat per cycle.
- Latency: first fifo_rd_en at cycle t gives m_valid=1 in cycle t+2.
- fifo_empty handling:
  - Sampled every cycle.
  - A word already in flight is still captured after fifo_empty rises.
  - The block never reads when fifo_empty=1.
- flush=1 at an edge:
  - occ, pointers and inflight clear.
  - Any word arriving from a read issued the previous cycle is discarded.
  - fifo_rd_en is 0 during the flush cycle.
  - m_valid drops the next cycle.
  - beat_cnt is not cleared.
  - A handshake with m_valid && m_ready in the flush cycle still counts as delivered.
- beat_cnt increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- Reset mid-stream: buffered and in-flight data are lost; after release the block restarts from empty.

Test Plan:
- Reset then streaming: preload FIFO with 0x11..0x18, fifo_empty=0, m_ready=1 -> fifo_rd_en at cycles 0..7; m_data 0x11..0x18 on consecutive cycles 2..9; beat_cnt=8.
- Backpressure: 5 words queued, m_ready=0 -> exactly 3 reads issued, occ=3, fifo_rd_en=0, m_data=first word stable; m_ready=1 -> all 5 words delivered in order, no loss or duplicate.
- Empty boundary: single word 0xA5, fifo_empty rises the cycle after the read -> one read only, 0xA5 delivered once, m_valid=0 afterwards, fifo_rd_en never high while fifo_empty=1.
- Flush: occ=2, inflight=1, flush pulsed 1 cycle -> next cycle m_valid=0, in-flight word not presented, beat_cnt unchanged; later words resume correctly.
- Counter wrap: CNT_W=4, deliver 17 beats -> beat_cnt sequence reaches 15, wraps to 0, ends at 1.
- Async reset mid-stream: reset_n low between clock edges while occ=2 -> outputs zero immediately; after release, with fifo_empty=1, m_valid stays 0 and beat_cnt=0.
